ram_controller: RTL

Single-port word memory with request/acknowledge front end. It services the ALU's `readReq`/`writeReq` strobes and returns `ramIn` with one-cycle `readAck`/`writeAck` pulses. A second, lower-priority host port loads programs and inspects memory. It sits directly downstream of the ALU and is the only agent that touches the memory array.

---
 rtl/ram_controller_if.sv | 34 +++
 rtl/ram_controller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_controller_if.sv
// Bus bundle between the ALU/host requesters and ram_controller.
// The master side issues strobes; the slave side returns data, acks and status.
interface ram_controller_if;
    logic [31:0] ramAddress;
    logic [31:0] ramOut;
    logic        readReq;
    logic        writeReq;
    logic [31:0] ramIn;
    logic        readAck;
    logic        writeAck;
    logic        hostReq;
    logic        hostWrite;
    logic [31:0] hostAddress;
    logic [31:0] hostWriteData;
    logic [31:0] hostReadData;
    logic        hostAck;
    logic        busy;
    logic        fault;
    logic [31:0] faultAddress;

    modport master (
        output ramAddress, ramOut, readReq, writeReq,
        output hostReq, hostWrite, hostAddress, hostWriteData,
        input  ramIn, readAck, writeAck, hostReadData, hostAck,
        input  busy, fault, faultAddress
    );

    modport slave (
        input  ramAddress, ramOut, readReq, writeReq,
        input  hostReq, hostWrite, hostAddress, hostWriteData,
        output ramIn, readAck, writeAck, hostReadData, hostAck,
        output busy, fault, faultAddress
    );
endinterface

// File: rtl/ram_controller.sv
// Single-port word memory serving an ALU port (priority) and a host port,
// each with a one-entry pending slot, plus a sticky address-fault recorder.
module ram_controller #(
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 2
) (
    input  logic            clk,
    input  logic            reset,
    ram_controller_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_ACK    = 2'd2
    } state_t;

    localparam int DEPTH = 1 << ADDR_WIDTH;

    state_t                  r_state;
    state_t                  w_state_nx;
    logic [31:0]             r_mem [DEPTH];

    logic                    r_alu_vld, r_alu_wr, r_alu_oor;
    logic [ADDR_WIDTH-1:0]   r_alu_idx;
    logic [31:0]             r_alu_data;
    logic                    r_host_vld, r_host_wr, r_host_oor;
    logic [ADDR_WIDTH-1:0]   r_host_idx;
    logic [31:0]             r_host_data;

    logic                    r_cur_alu, r_cur_wr, r_cur_oor;
    logic [ADDR_WIDTH-1:0]   r_cur_idx;
    logic [3:0]              r_cnt;

    logic [31:0]             r_ram_in, r_host_rd_data, r_fault_addr;
    logic                    r_read_ack, r_write_ack, r_host_ack, r_fault;

    logic                    w_start, w_sel_alu, w_to_ack;
    logic                    w_alu_strobe, w_alu_oor, w_alu_bad;
    logic                    w_host_oor, w_host_bad;
    logic                    w_sel_wr, w_sel_oor;
    logic [ADDR_WIDTH-1:0]   w_sel_idx;
    logic [31:0]             w_sel_data, w_rd_data;

    assign w_alu_strobe = bus.readReq | bus.writeReq;
    assign w_alu_oor    = |bus.ramAddress[31:ADDR_WIDTH+2];
    assign w_alu_bad    = (bus.ramAddress[1:0] != 2'b00) | w_alu_oor
                        | (bus.readReq & bus.writeReq) | r_alu_vld;
    assign w_host_oor   = |bus.hostAddress[31:ADDR_WIDTH+2];
    assign w_host_bad   = (bus.hostAddress[1:0] != 2'b00) | w_host_oor | r_host_vld;

    assign w_sel_wr   = w_sel_alu ? r_alu_wr   : r_host_wr;
    assign w_sel_oor  = w_sel_alu ? r_alu_oor  : r_host_oor;
    assign w_sel_idx  = w_sel_alu ? r_alu_idx  : r_host_idx;
    assign w_sel_data = w_sel_alu ? r_alu_data : r_host_data;
    assign w_rd_data  = r_cur_oor ? 32'h0000_0000 : r_mem[r_cur_idx];

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state: ALU wins in IDLE; ACK chains straight into the other port's pending slot
    always_comb begin
        w_state_nx = r_state;
        w_start    = 1'b0;
        w_sel_alu  = 1'b0;
        w_to_ack   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_alu_vld || r_host_vld) begin
                    w_start    = 1'b1;
                    w_sel_alu  = r_alu_vld;
                    w_state_nx = S_ACCESS;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_ACCESS: begin
                if (r_cur_wr || (r_cnt == 4'd0)) begin
                    w_to_ack   = 1'b1;
                    w_state_nx = S_ACK;
                end else begin
                    w_state_nx = S_ACCESS;
                end
            end
            S_ACK: begin
                if (r_cur_alu && r_host_vld) begin
                    w_start    = 1'b1;
                    w_sel_alu  = 1'b0;
                    w_state_nx = S_ACCESS;
                end else if (!r_cur_alu && r_alu_vld) begin
                    w_start    = 1'b1;
                    w_sel_alu  = 1'b1;
                    w_state_nx = S_ACCESS;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Pending slots: a new strobe always overwrites; the served slot empties on its ACK
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_alu_vld   <= 1'b0;
            r_alu_wr    <= 1'b0;
            r_alu_oor   <= 1'b0;
            r_alu_idx   <= '0;
            r_alu_data  <= 32'h0000_0000;
            r_host_vld  <= 1'b0;
            r_host_wr   <= 1'b0;
            r_host_oor  <= 1'b0;
            r_host_idx  <= '0;
            r_host_data <= 32'h0000_0000;
        end else begin
            if (w_alu_strobe) begin
                r_alu_vld  <= 1'b1;
                r_alu_wr   <= bus.writeReq;
                r_alu_oor  <= w_alu_oor;
                r_alu_idx  <= bus.ramAddress[ADDR_WIDTH+1:2];
                r_alu_data <= bus.ramOut;
            end else if ((r_state == S_ACK) && r_cur_alu) begin
                r_alu_vld  <= 1'b0;
            end
            if (bus.hostReq) begin
                r_host_vld  <= 1'b1;
                r_host_wr   <= bus.hostWrite;
                r_host_oor  <= w_host_oor;
                r_host_idx  <= bus.hostAddress[ADDR_WIDTH+1:2];
                r_host_data <= bus.hostWriteData;
            end else if ((r_state == S_ACK) && !r_cur_alu) begin
                r_host_vld  <= 1'b0;
            end
        end
    end

    // Latch the access being served so later strobes cannot disturb it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cur_alu <= 1'b0;
            r_cur_wr  <= 1'b0;
            r_cur_oor <= 1'b0;
            r_cur_idx <= '0;
            r_cnt     <= 4'd0;
        end else if (w_start) begin
            r_cur_alu <= w_sel_alu;
            r_cur_wr  <= w_sel_wr;
            r_cur_oor <= w_sel_oor;
            r_cur_idx <= w_sel_idx;
            r_cnt     <= 4'(READ_LATENCY - 1);
        end else if ((r_state == S_ACCESS) && (r_cnt != 4'd0)) begin
            r_cnt     <= r_cnt - 4'd1;
        end
    end

    // Array write commits on ACCESS entry; out-of-range writes are dropped
    always_ff @(posedge clk) begin
        if (reset && w_start && w_sel_wr && !w_sel_oor) begin
            r_mem[w_sel_idx] <= w_sel_data;
        end
    end

    // Ack pulses and read-data holding registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_read_ack     <= 1'b0;
            r_write_ack    <= 1'b0;
            r_host_ack     <= 1'b0;
            r_ram_in       <= 32'h0000_0000;
            r_host_rd_data <= 32'h0000_0000;
        end else begin
            r_read_ack  <= w_to_ack & r_cur_alu & ~r_cur_wr;
            r_write_ack <= w_to_ack & r_cur_alu & r_cur_wr;
            r_host_ack  <= w_to_ack & ~r_cur_alu;
            if (w_to_ack && r_cur_alu && !r_cur_wr) begin
                r_ram_in <= w_rd_data;
            end
            if (w_to_ack && !r_cur_alu && !r_cur_wr) begin
                r_host_rd_data <= w_rd_data;
            end
        end
    end

    // Sticky fault; only the first offending address is kept, ALU reported ahead of host
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fault      <= 1'b0;
            r_fault_addr <= 32'h0000_0000;
        end else if (w_alu_strobe && w_alu_bad) begin
            r_fault <= 1'b1;
            if (!r_fault) begin
                r_fault_addr <= bus.ramAddress;
            end
        end else if (bus.hostReq && w_host_bad) begin
            r_fault <= 1'b1;
            if (!r_fault) begin
                r_fault_addr <= bus.hostAddress;
            end
        end
    end

    assign bus.ramIn        = r_ram_in;
    assign bus.readAck      = r_read_ack;
    assign bus.writeAck     = r_write_ack;
    assign bus.hostReadData = r_host_rd_data;
    assign bus.hostAck      = r_host_ack;
    assign bus.fault        = r_fault;
    assign bus.faultAddress = r_fault_addr;
    assign bus.busy         = (r_state != S_IDLE) | r_alu_vld | r_host_vld;
endmodule
